radix2_divider: RTL and testbench

Sequential signed two's-complement divider, one quotient bit per clock, using non-restoring division on operand magnitudes. It is the inverse companion of the Booth multiplier datapath and sits beside it in the arithmetic lab. A start/busy/done handshake connects it to a control FSM or a testbench. Quotient truncates toward zero, and the remainder takes the sign of the dividend.

---
 rtl/radix2_divider_pkg.sv | 22 ++
 rtl/radix2_divider_nr_div_step.sv | 21 ++
 rtl/radix2_divider.sv | 153 +++++++++++++++
 tb/tb_radix2_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/radix2_divider_pkg.sv
// Shared constants for the radix-2 divider: default operand width and FSM state encodings.
// The DIV_SIZE macro may be predefined by the build; it falls back to 8 here.
`ifndef DIV_SIZE
`define DIV_SIZE 8
`endif

package radix2_divider_pkg;

  localparam int DIV_DEFAULT_SIZE = `DIV_SIZE;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic div_is_busy(input div_state_e s);
    return (s == DIV_RUN) || (s == DIV_FIX);
  endfunction

endpackage

// File: rtl/radix2_divider_nr_div_step.sv
// One combinational non-restoring division step on magnitudes:
// shift the next dividend bit into P, then subtract or add D depending on P's sign.
module nr_div_step
  import radix2_divider_pkg::*;
#(
  parameter int SIZE = DIV_DEFAULT_SIZE
) (
  input  logic [SIZE:0]   p_i,
  input  logic            q_msb_i,
  input  logic [SIZE-1:0] d_i,
  output logic [SIZE:0]   p_o,
  output logic            q_bit_o
);

  logic [SIZE:0] p_shift;

  assign p_shift = {p_i[SIZE-1:0], q_msb_i};
  assign p_o     = p_i[SIZE] ? (p_shift + {1'b0, d_i}) : (p_shift - {1'b0, d_i});
  assign q_bit_o = ~p_o[SIZE];

endmodule

// File: rtl/radix2_divider.sv
// Sequential signed divider, one quotient bit per clock (non-restoring on magnitudes).
// Optional macro DIV_ZERO_DETECT_EN: zero divisor short-circuits to DONE and raises div_by_zero.
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter int SIZE = DIV_DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  div_state_e      state_q, state_d;
  logic [SIZE:0]   p_q, p_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [SIZE-1:0] quo_q, quo_d;
  logic [SIZE-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_DETECT_EN
  logic            dbz_q, dbz_d;
`endif

  logic [SIZE-1:0] dvd_mag, dvs_mag;
  logic [SIZE:0]   step_p, p_fix;
  logic            step_qbit;
  logic            unused_fix_msb;

  assign dvd_mag = dividend[SIZE-1] ? -dividend : dividend;
  assign dvs_mag = divisor[SIZE-1]  ? -divisor  : divisor;

  nr_div_step #(.SIZE(SIZE)) u_step (
    .p_i     (p_q),
    .q_msb_i (q_q[SIZE-1]),
    .d_i     (d_q),
    .p_o     (step_p),
    .q_bit_o (step_qbit)
  );

  // Final correction: a negative partial remainder is restored by one add of D.
  assign p_fix          = p_q[SIZE] ? (p_q + {1'b0, d_q}) : p_q;
  assign unused_fix_msb = p_fix[SIZE];

  always_comb begin
    // NOTE: every next-state signal defaults to its held value first so no latch is inferred.
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif

    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (start) begin
          q_d     = dvd_mag;
          d_d     = dvs_mag;
          qneg_d  = dividend[SIZE-1] ^ divisor[SIZE-1];
          rneg_d  = dividend[SIZE-1];
          p_d     = '0;
          cnt_d   = CNT_LAST;
          state_d = DIV_RUN;
`ifdef DIV_ZERO_DETECT_EN
          dbz_d   = (divisor == '0);
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            state_d = DIV_DONE;
          end
`endif
        end else if (state_q == DIV_DONE) begin
          state_d = DIV_IDLE;
        end
      end

      DIV_RUN: begin
        p_d   = step_p;
        q_d   = {q_q[SIZE-2:0], step_qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DIV_FIX;
      end

      DIV_FIX: begin
        p_d     = p_fix;
        quo_d   = qneg_q ? -q_q : q_q;
        rem_d   = rneg_q ? -p_fix[SIZE-1:0] : p_fix[SIZE-1:0];
        state_d = DIV_DONE;
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy      = div_is_busy(state_q);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_radix2_divider.sv
// Scoreboard bench for radix2_divider (SIZE=8): stimulus pushes expected results computed with
// integer division; a monitor pops and compares whenever done is seen.
module tb_radix2_divider;

  localparam int SIZE = 8;

  typedef struct {
    logic [SIZE-1:0] quo;
    logic [SIZE-1:0] rem;
    logic            dbz;
    int              acc;
    int              lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [SIZE-1:0] dividend = '0;
  logic [SIZE-1:0] divisor = '0;
  logic            busy, done, div_by_zero;
  logic [SIZE-1:0] quotient, remainder;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_cmp = 0;
  exp_t sb[$];

  radix2_divider #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: truncating integer division, remainder follows the dividend's sign.
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    int   q, r;
    e.acc = acc;
    e.lat = SIZE + 2;
    e.dbz = 1'b0;
    if (b == 0) begin
      r = a;
`ifdef DIV_ZERO_DETECT_EN
      q     = -1;
      e.dbz = 1'b1;
      e.lat = 1;
`else
      q = (a >= 0) ? -1 : 1;
`endif
    end else begin
      q = a / b;
      r = a % b;
    end
    e.quo = q[SIZE-1:0];
    e.rem = r[SIZE-1:0];
    return e;
  endfunction

  task automatic issue(input logic signed [SIZE-1:0] a, input logic signed [SIZE-1:0] b,
                       input bit hold);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      miscompares++;
      $display("FAIL issue_timeout: busy=%0b, required 0", busy);
      return;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(int'(a), int'(b), cyc));
    vectors++;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got quotient %0d remainder %0d, required no done",
                   $signed(quotient), $signed(remainder));
        end else begin
          e = sb.pop_front();
          check("quotient", int'($signed(quotient)), int'($signed(e.quo)));
          check("remainder", int'($signed(remainder)), int'($signed(e.rem)));
          check("div_by_zero", int'(div_by_zero), int'(e.dbz));
          check("latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, including overflow, sign combinations and zero divisor.
    issue(8'sd100, 8'sd7, 0);
    issue(-8'sd100, 8'sd7, 0);
    issue(8'sd100, -8'sd7, 0);
    issue(-8'sd100, -8'sd7, 0);
    issue(-8'sd128, -8'sd1, 0);
    issue(-8'sd128, 8'sd1, 0);
    issue(8'sd5, 8'sd9, 0);
    issue(8'sd12, 8'sd0, 0);
    issue(-8'sd12, 8'sd0, 0);

    // A start pulse mid-computation must be ignored along with its operands.
    issue(8'sd100, 8'sd7, 0);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'sd50;
    divisor  = 8'sd3;
    @(negedge clk);
    start = 1'b0;

    // Start held high through DONE: the new operands are taken there.
    issue(8'sd100, 8'sd7, 1);
    @(negedge clk);
    dividend = 8'sd50;
    divisor  = 8'sd3;
    guard    = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("held_start_reached_done", int'(done), 1);
    sb.push_back(model(50, 3, cyc));
    vectors++;
    @(negedge clk);
    start = 1'b0;

    // Asynchronous reset during RUN clears everything at once.
    issue(8'sd100, 8'sd7, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_done", int'(done), 0);
    check("midrun_rst_quotient", int'(quotient), 0);
    check("midrun_rst_remainder", int'(remainder), 0);
    check("midrun_rst_dbz", int'(div_by_zero), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_idle_busy", int'(busy), 0);
    issue(8'sd9, 8'sd2, 0);

    // Random operands, with an occasional zero divisor.
    for (int i = 0; i < 60; i++) begin
      logic [SIZE-1:0] a, b;
      a = SIZE'($urandom);
      b = ($urandom_range(0, 9) == 0) ? '0 : SIZE'($urandom);
      issue(a, b, 0);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
